// File: rtl/hps_readback_fifo.sv
// hps_readback_fifo
//   FPGA-to-HPS return path. Fabric logic pushes 32-bit words into a small
//   FIFO. The HPS drains it through a two-word read window: address 0 pops a
//   data word and address 1 returns a status word. Reads have one cycle of
//   latency. Sticky overflow and underflow flags record lost or invalid
//   transfers, and a status read clears them.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   push_valid   fabric offers push_data this cycle
//   push_data    word to enqueue
//   push_ready   FIFO can accept (!full && !rst), combinational
//   read_enable  HPS read strobe, one cycle per read
//   read_addr    0 = pop data word, 1 = status word
//   read_data    registered read result, held between reads
//   read_valid   high for one cycle when read_data has been updated
module hps_readback_fifo #(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push_valid,
   input  logic [31:0] push_data,
   output logic        push_ready,
   input  logic        read_enable,
   input  logic        read_addr,
   output logic [31:0] read_data,
   output logic        read_valid
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW:0]   count;
   logic          overflow;
   logic          underflow;

   logic          full;
   logic          empty;
   logic          push_acc;
   logic          ovf_evt;
   logic          pop_req;
   logic          pop_ok;
   logic          pop_under;
   logic          stat_req;

   logic [31:0]   rd_data_p1;
   logic          vld_p1;

   // Status word layout: count in [15:8], flags in [3:0].
   function automatic logic [31:0] pack_status(input logic [AW:0] cnt,
                                               input logic        unf,
                                               input logic        ovf,
                                               input logic        ful,
                                               input logic        emp);
      pack_status = {16'h0000, 8'(cnt), 4'h0, unf, ovf, ful, emp};
   endfunction

   assign full       = (count == CNT_FULL);
   assign empty      = (count == '0);
   assign push_ready = !full && !rst;

   // Full is judged on the registered count, so a pop in the same cycle
   // does not make room for a push.
   assign push_acc  = push_valid && push_ready;
   assign ovf_evt   = push_valid && full;
   assign pop_req   = read_enable && !read_addr;
   assign pop_ok    = pop_req && !empty;
   assign pop_under = pop_req && empty;
   assign stat_req  = read_enable && read_addr;

   // Storage array is not reset. Its contents are unreachable while count is 0.
   always_ff @(posedge clk) begin
      if (push_acc) begin
         mem[wptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr      <= '0;
         rptr      <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push_acc) begin
            wptr <= wptr + PTR_ONE;
         end
         if (pop_ok) begin
            rptr <= rptr + PTR_ONE;
         end
         case ({push_acc, pop_ok})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         // A new event in the same cycle as a status read keeps the flag set.
         overflow  <= ovf_evt   || (overflow  && !stat_req);
         underflow <= pop_under || (underflow && !stat_req);
      end
   end

   // ---- stage p1: registered read result ----
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_p1 <= 32'h0000_0000;
         vld_p1     <= 1'b0;
      end else begin
         vld_p1 <= read_enable;
         if (pop_ok) begin
            rd_data_p1 <= mem[rptr];
         end else if (pop_under) begin
            rd_data_p1 <= 32'h0000_0000;
         end else if (stat_req) begin
            rd_data_p1 <= pack_status(count, underflow, overflow, full, empty);
         end
      end
   end

   assign read_data  = rd_data_p1;
   assign read_valid = vld_p1;

endmodule

// File: tb/tb_hps_readback_fifo.sv
// tb_hps_readback_fifo
//   Directed bench for hps_readback_fifo at DEPTH = 8. Inputs change on the
//   falling edge. Outputs are sampled 1 ns after the rising edge.
module tb_hps_readback_fifo;

   logic        clk;
   logic        rst;
   logic        push_valid;
   logic [31:0] push_data;
   logic        push_ready;
   logic        read_enable;
   logic        read_addr;
   logic [31:0] read_data;
   logic        read_valid;

   int checks = 0;
   int errors = 0;

   hps_readback_fifo #(.DEPTH(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .push_valid  (push_valid),
      .push_data   (push_data),
      .push_ready  (push_ready),
      .read_enable (read_enable),
      .read_addr   (read_addr),
      .read_data   (read_data),
      .read_valid  (read_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc(input logic r, input logic pv, input logic [31:0] pd,
                      input logic re, input logic ra);
      @(negedge clk);
      rst         = r;
      push_valid  = pv;
      push_data   = pd;
      read_enable = re;
      read_addr   = ra;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pop_chk(input string tag, input logic [31:0] exp);
      cyc(0, 0, 0, 1, 0);
      chk({tag, "_data"}, read_data, exp);
      chk({tag, "_vld"}, {31'b0, read_valid}, 32'h1);
   endtask

   task automatic stat_chk(input string tag, input logic [31:0] exp);
      cyc(0, 0, 0, 1, 1);
      chk(tag, read_data, exp);
   endtask

   initial begin
      rst = 1'b1; push_valid = 1'b0; push_data = '0; read_enable = 1'b0; read_addr = 1'b0;

      // Reset state
      cyc(1, 1, 32'hDEAD_BEEF, 1, 0);
      cyc(1, 0, 0, 1, 1);
      chk("rst_ready", {31'b0, push_ready}, 32'h0);
      chk("rst_vld", {31'b0, read_valid}, 32'h0);
      chk("rst_data", read_data, 32'h0);
      cyc(0, 0, 0, 0, 0);
      chk("ready_after_rst", {31'b0, push_ready}, 32'h1);
      chk("vld_idle", {31'b0, read_valid}, 32'h0);
      stat_chk("stat_reset", 32'h0000_0001);
      chk("stat_reset_vld", {31'b0, read_valid}, 32'h1);
      cyc(0, 0, 0, 0, 0);
      chk("vld_one_cycle", {31'b0, read_valid}, 32'h0);
      chk("data_hold", read_data, 32'h0000_0001);

      // Basic order
      cyc(0, 1, 32'hA000_0001, 0, 0);
      cyc(0, 1, 32'hA000_0002, 0, 0);
      cyc(0, 1, 32'hA000_0003, 0, 0);
      pop_chk("pop1", 32'hA000_0001);
      pop_chk("pop2", 32'hA000_0002);
      pop_chk("pop3", 32'hA000_0003);
      stat_chk("stat_drained", 32'h0000_0001);

      // Fill to full, ninth push dropped
      for (int i = 0; i < 8; i++) cyc(0, 1, 32'hB000_0000 + i, 0, 0);
      chk("ready_full", {31'b0, push_ready}, 32'h0);
      cyc(0, 1, 32'hB000_0008, 0, 0);
      stat_chk("stat_ovf", 32'h0000_0806);
      stat_chk("stat_ovf_clr", 32'h0000_0802);

      // Push and pop on a full FIFO: pop wins, push dropped
      cyc(0, 1, 32'hC000_0000, 1, 0);
      chk("full_pp_data", read_data, 32'hB000_0000);
      stat_chk("stat_full_pp", 32'h0000_0704);
      for (int i = 1; i < 8; i++) pop_chk("drain", 32'hB000_0000 + i);

      // Underflow
      pop_chk("pop_empty", 32'h0000_0000);
      stat_chk("stat_unf", 32'h0000_0009);
      stat_chk("stat_unf_clr", 32'h0000_0001);

      // Push and pop on empty: pop underflows, push accepted
      cyc(0, 1, 32'hE000_0000, 1, 0);
      chk("pp_empty_data", read_data, 32'h0000_0000);
      stat_chk("stat_pp_empty", 32'h0000_0108);
      pop_chk("pp_empty_pop", 32'hE000_0000);

      // Streaming across pointer wrap, count held at 1
      cyc(0, 1, 32'hD000_0000, 0, 0);
      for (int i = 0; i < 20; i++) begin
         cyc(0, 1, 32'hD000_0001 + i, 1, 0);
         chk("wrap", read_data, 32'hD000_0000 + i);
      end
      stat_chk("stat_wrap", 32'h0000_0100);
      pop_chk("wrap_last", 32'hD000_0014);

      // Reset mid-stream with a pending read strobe
      cyc(0, 1, 32'hF000_0000, 0, 0);
      cyc(0, 1, 32'hF000_0001, 0, 0);
      cyc(0, 1, 32'hF000_0002, 0, 0);
      cyc(1, 1, 32'hF000_0003, 1, 0);
      chk("mid_rst_vld", {31'b0, read_valid}, 32'h0);
      chk("mid_rst_data", read_data, 32'h0);
      stat_chk("stat_after_rst", 32'h0000_0001);
      pop_chk("pop_after_rst", 32'h0000_0000);
      cyc(0, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
